// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared encodings for the PC sequencer and the next-address mux that consumes
// its select output.
//   pc_sel_e      : next-address mux select codes
//   fault_code_e  : sticky fault reason reported by the sequencer
//   seq_state_e   : sequencer control states
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PC_SEL_STACK  = 3'b000,
        PC_SEL_JR     = 3'b001,
        PC_SEL_NPC    = 3'b010,
        PC_SEL_BRANCH = 3'b011,
        PC_SEL_HALT   = 3'b100
    } pc_sel_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'b00,
        FAULT_OVERFLOW  = 2'b01,
        FAULT_UNDERFLOW = 2'b10
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// LIFO of return addresses with an occupancy counter that never wraps.
// Ports:
//   clock, reset : clock and synchronous active-high reset (clears pointer only)
//   push, pop    : push push_data / drop the top entry on the next edge
//   push_data    : address to push
//   top          : most recent unpopped entry, 0 when empty
//   depth        : current occupancy, 0..DEPTH
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module return_stack #(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] entries [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  top_index;

    // Occupancy flags and the top-of-stack read. Because DEPTH is a power of
    // two, the low pointer bits minus one land on the right slot even when the
    // counter sits exactly at DEPTH.
    assign full      = (count_q == CAPACITY);
    assign empty     = (count_q == '0);
    assign depth     = count_q;
    assign top_index = count_q[PTR_W-1:0] - PTR_ONE;
    assign top       = empty ? '0 : entries[top_index];

    // Occupancy counter. Push is refused when full and pop when empty, so the
    // pointer stays inside 0..DEPTH whatever the caller asks for.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CNT_ONE;
        end else if (pop && !empty) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    // Entry storage. Contents are not cleared on reset; the counter alone
    // decides which entries are live.
    always_ff @(posedge clock) begin
        if (!reset && push && !full) begin
            entries[count_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Control-flow sequencer: decodes the control class of the current instruction
// into a next-address mux select, manages the return-address stack and tracks
// RUN / HALTED / FAULT state.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   stall                 : pipeline stall, freezes PC and stack
//   instr_valid           : decode-stage control inputs valid
//   is_branch, branch_taken, is_jr, is_call, is_ret, is_halt : control class
//   resume                : leave HALTED
//   pc_1                  : PC+1, pushed as return address on call
//   pc_select             : next-address mux select (combinational)
//   stack_top             : top return-stack entry
//   stack_depth           : return-stack occupancy
//   halted, fault         : state flags
//   fault_code            : sticky fault reason, cleared only by reset
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter  int STACK_DEPTH = 8,
    parameter  int ADDR_W      = 32,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               instr_valid,
    input  logic               is_branch,
    input  logic               branch_taken,
    input  logic               is_jr,
    input  logic               is_call,
    input  logic               is_ret,
    input  logic               is_halt,
    input  logic               resume,
    input  logic [ADDR_W-1:0]  pc_1,
    output logic [2:0]         pc_select,
    output logic [ADDR_W-1:0]  stack_top,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               halted,
    output logic               fault,
    output logic [1:0]         fault_code
);

    seq_state_e  state_q;
    seq_state_e  state_next;
    fault_code_e fault_q;
    fault_code_e fault_next;
    pc_sel_e     sel;
    logic        do_push;
    logic        do_pop;
    logic        stack_full;
    logic        stack_empty;

    return_stack #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_1),
        .top       (stack_top),
        .depth     (stack_depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // State and sticky fault code register. The fault code only changes on the
    // transition into FAULT, so once set it holds until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_next;
            fault_q <= fault_next;
        end
    end

    // Next-state and select decode. The select is purely combinational so the
    // mux sees it in the same cycle; stack and state follow on the next edge.
    // In RUN the flags are taken in strict priority order and lower-priority
    // flags are ignored. A ret on an empty stack or a call on a full stack
    // parks the machine in FAULT instead of touching the stack. Reset forces
    // the NPC select regardless of state.
    always_comb begin
        sel        = PC_SEL_NPC;
        state_next = state_q;
        fault_next = fault_q;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (stall) begin
                    sel = PC_SEL_HALT;
                end else if (instr_valid) begin
                    if (is_halt) begin
                        sel        = PC_SEL_HALT;
                        state_next = ST_HALTED;
                    end else if (is_ret) begin
                        if (!stack_empty) begin
                            sel    = PC_SEL_STACK;
                            do_pop = 1'b1;
                        end else begin
                            sel        = PC_SEL_HALT;
                            fault_next = FAULT_UNDERFLOW;
                            state_next = ST_FAULT;
                        end
                    end else if (is_call) begin
                        if (!stack_full) begin
                            sel     = PC_SEL_BRANCH;
                            do_push = 1'b1;
                        end else begin
                            sel        = PC_SEL_HALT;
                            fault_next = FAULT_OVERFLOW;
                            state_next = ST_FAULT;
                        end
                    end else if (is_jr) begin
                        sel = PC_SEL_JR;
                    end else if (is_branch && branch_taken) begin
                        sel = PC_SEL_BRANCH;
                    end
                end
            end
            ST_HALTED: begin
                sel = PC_SEL_HALT;
                if (resume) begin
                    state_next = ST_RUN;
                end
            end
            ST_FAULT: begin
                sel = PC_SEL_HALT;
            end
            default: begin
                sel        = PC_SEL_HALT;
                state_next = ST_FAULT;
            end
        endcase
        if (reset) begin
            sel     = PC_SEL_NPC;
            do_push = 1'b0;
            do_pop  = 1'b0;
        end
    end

    // Status outputs taken straight from the registered state.
    assign pc_select  = sel;
    assign halted     = (state_q == ST_HALTED);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a vector table, hand-written sequences
// for stack-limit, fault and halt corner cases, then random traffic against a
// queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int DEPTH = 8;

    localparam logic [8:0] C_STALL  = 9'h001;
    localparam logic [8:0] C_VALID  = 9'h002;
    localparam logic [8:0] C_BR     = 9'h004;
    localparam logic [8:0] C_TAKEN  = 9'h008;
    localparam logic [8:0] C_JR     = 9'h010;
    localparam logic [8:0] C_CALL   = 9'h020;
    localparam logic [8:0] C_RET    = 9'h040;
    localparam logic [8:0] C_HALT   = 9'h080;
    localparam logic [8:0] C_RESUME = 9'h100;

    localparam logic [2:0] S_STACK  = 3'b000;
    localparam logic [2:0] S_JR     = 3'b001;
    localparam logic [2:0] S_NPC    = 3'b010;
    localparam logic [2:0] S_BRANCH = 3'b011;
    localparam logic [2:0] S_HALT   = 3'b100;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic [3:0]  depth;
        logic [31:0] top;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        instr_valid;
    logic        is_branch;
    logic        branch_taken;
    logic        is_jr;
    logic        is_call;
    logic        is_ret;
    logic        is_halt;
    logic        resume;
    logic [31:0] pc_1;
    logic [2:0]  pc_select;
    logic [31:0] stack_top;
    logic [3:0]  stack_depth;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t vecs [14];

    int          m_state;
    logic [31:0] m_stack [$];
    logic [1:0]  m_code;

    pc_sequencer #(
        .STACK_DEPTH (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .instr_valid  (instr_valid),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .is_jr        (is_jr),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .is_halt      (is_halt),
        .resume       (resume),
        .pc_1         (pc_1),
        .pc_select    (pc_select),
        .stack_top    (stack_top),
        .stack_depth  (stack_depth),
        .halted       (halted),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs shortly after the clock edge and let the
    // combinational select settle.
    task automatic applyStimulus(input logic rst, input logic [8:0] c,
                                 input logic [31:0] pc);
        reset        = rst;
        stall        = c[0];
        instr_valid  = c[1];
        is_branch    = c[2];
        branch_taken = c[3];
        is_jr        = c[4];
        is_call      = c[5];
        is_ret       = c[6];
        is_halt      = c[7];
        resume       = c[8];
        pc_1         = pc;
        #2;
    endtask

    // Apply inputs, check the same-cycle select, then advance past the edge.
    task automatic stepCheck(input string name, input logic rst, input logic [8:0] c,
                             input logic [31:0] pc, input logic [2:0] exp_sel);
        applyStimulus(rst, c, pc);
        checkOutput({name, ".pc_select"}, 64'(pc_select), 64'(exp_sel));
        @(posedge clock);
        #1;
    endtask

    // Check the registered status outputs after an edge.
    task automatic checkState(input string name, input int exp_depth,
                              input logic [31:0] exp_top, input logic exp_fault,
                              input logic [1:0] exp_code, input logic exp_halted);
        checkOutput({name, ".depth"},  64'(stack_depth), 64'(exp_depth));
        checkOutput({name, ".top"},    64'(stack_top),   64'(exp_top));
        checkOutput({name, ".fault"},  64'(fault),       64'(exp_fault));
        checkOutput({name, ".code"},   64'(fault_code),  64'(exp_code));
        checkOutput({name, ".halted"}, 64'(halted),      64'(exp_halted));
    endtask

    // Reference model: select from the rules of the current state and inputs.
    function automatic logic [2:0] modelSel(input logic rst, input logic [8:0] c);
        if (rst) return S_NPC;
        if (m_state != 0) return S_HALT;
        if (c[0]) return S_HALT;
        if (!c[1]) return S_NPC;
        if (c[7]) return S_HALT;
        if (c[6]) return (m_stack.size() > 0) ? S_STACK : S_HALT;
        if (c[5]) return (m_stack.size() < DEPTH) ? S_BRANCH : S_HALT;
        if (c[4]) return S_JR;
        if (c[2] && c[3]) return S_BRANCH;
        return S_NPC;
    endfunction

    // Reference model: apply one clock edge.
    task automatic modelEdge(input logic rst, input logic [8:0] c, input logic [31:0] pc);
        if (rst) begin
            m_state = 0;
            m_stack.delete();
            m_code  = 2'b00;
        end else if (m_state == 0) begin
            if (!c[0] && c[1]) begin
                if (c[7]) begin
                    m_state = 1;
                end else if (c[6]) begin
                    if (m_stack.size() > 0) void'(m_stack.pop_back());
                    else begin m_state = 2; m_code = 2'b10; end
                end else if (c[5]) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(pc);
                    else begin m_state = 2; m_code = 2'b01; end
                end
            end
        end else if (m_state == 1) begin
            if (c[8]) m_state = 0;
        end
    endtask

    initial begin
        logic [8:0]  c;
        logic [31:0] pc;
        logic        rst;
        logic [2:0]  esel;

        applyStimulus(1'b1, 9'h000, 32'h0);
        @(posedge clock);
        #1;

        // Reset wins and forces the NPC select even with stall and flags.
        stepCheck("reset_sel", 1'b1, C_STALL | C_VALID | C_CALL, 32'h55, S_NPC);
        checkState("reset", 0, 32'h0, 1'b0, 2'b00, 1'b0);

        vecs[0]  = '{C_VALID,                    32'h0,   S_NPC,    4'd0, 32'h0};
        vecs[1]  = '{C_VALID,                    32'h0,   S_NPC,    4'd0, 32'h0};
        vecs[2]  = '{C_VALID | C_CALL,           32'h100, S_BRANCH, 4'd1, 32'h100};
        vecs[3]  = '{C_VALID | C_CALL,           32'h200, S_BRANCH, 4'd2, 32'h200};
        vecs[4]  = '{C_VALID | C_RET,            32'h0,   S_STACK,  4'd1, 32'h100};
        vecs[5]  = '{C_VALID | C_RET,            32'h0,   S_STACK,  4'd0, 32'h0};
        vecs[6]  = '{C_VALID | C_CALL,           32'h300, S_BRANCH, 4'd1, 32'h300};
        vecs[7]  = '{C_STALL | C_VALID | C_CALL | C_RET, 32'h400, S_HALT, 4'd1, 32'h300};
        vecs[8]  = '{C_VALID | C_CALL | C_RET,   32'h400, S_STACK,  4'd0, 32'h0};
        vecs[9]  = '{C_VALID | C_JR,             32'h0,   S_JR,     4'd0, 32'h0};
        vecs[10] = '{C_VALID | C_BR | C_TAKEN,   32'h0,   S_BRANCH, 4'd0, 32'h0};
        vecs[11] = '{C_VALID | C_BR,             32'h0,   S_NPC,    4'd0, 32'h0};
        vecs[12] = '{C_BR | C_TAKEN | C_CALL,    32'h9,   S_NPC,    4'd0, 32'h0};
        vecs[13] = '{C_VALID | C_JR | C_BR | C_TAKEN, 32'h0, S_JR,  4'd0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            stepCheck($sformatf("vec%0d", i), 1'b0, vecs[i].ctrl, vecs[i].pc, vecs[i].sel);
            checkOutput($sformatf("vec%0d.depth", i), 64'(stack_depth), 64'(vecs[i].depth));
            checkOutput($sformatf("vec%0d.top", i),   64'(stack_top),   64'(vecs[i].top));
            checkOutput($sformatf("vec%0d.fault", i), 64'(fault),       64'(0));
        end

        // Fill the stack, drain it in LIFO order, refill and overflow.
        for (int i = 0; i < DEPTH; i++)
            stepCheck("fill", 1'b0, C_VALID | C_CALL, 32'h1000 + 32'(i), S_BRANCH);
        checkState("full", DEPTH, 32'h1007, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("lifo.top", 64'(stack_top), 64'(32'h1000 + 32'(DEPTH - 1 - i)));
            stepCheck("lifo", 1'b0, C_VALID | C_RET, 32'h0, S_STACK);
        end
        checkState("drained", 0, 32'h0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            stepCheck("refill", 1'b0, C_VALID | C_CALL, 32'h2000 + 32'(i), S_BRANCH);
        stepCheck("overflow", 1'b0, C_VALID | C_CALL, 32'h2008, S_HALT);
        checkState("overflow", DEPTH, 32'h2007, 1'b1, 2'b01, 1'b0);
        stepCheck("fault_hold0", 1'b0, C_RESUME, 32'h0, S_HALT);
        stepCheck("fault_hold1", 1'b0, C_VALID | C_RET | C_RESUME, 32'h0, S_HALT);
        stepCheck("fault_hold2", 1'b0, C_VALID, 32'h0, S_HALT);
        checkState("fault_hold", DEPTH, 32'h2007, 1'b1, 2'b01, 1'b0);
        stepCheck("ovf_reset", 1'b1, C_VALID | C_CALL, 32'h0, S_NPC);
        checkState("ovf_reset", 0, 32'h0, 1'b0, 2'b00, 1'b0);

        // Underflow, then reset out of FAULT.
        stepCheck("underflow", 1'b0, C_VALID | C_RET, 32'h0, S_HALT);
        checkState("underflow", 0, 32'h0, 1'b1, 2'b10, 1'b0);
        stepCheck("udf_resume", 1'b0, C_RESUME, 32'h0, S_HALT);
        checkState("udf_resume", 0, 32'h0, 1'b1, 2'b10, 1'b0);
        stepCheck("udf_reset", 1'b1, 9'h000, 32'h0, S_NPC);
        checkState("udf_reset", 0, 32'h0, 1'b0, 2'b00, 1'b0);
        stepCheck("udf_after", 1'b0, C_VALID, 32'h0, S_NPC);

        // Halt, hold for five cycles with stall toggling, resume while stalled.
        stepCheck("halt", 1'b0, C_VALID | C_CALL | C_HALT, 32'h77, S_HALT);
        checkState("halted", 0, 32'h0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++)
            stepCheck("halt_hold", 1'b0, ((i % 2) ? C_STALL : 9'h000) | C_VALID | C_CALL,
                      32'h88, S_HALT);
        checkState("halt_hold", 0, 32'h0, 1'b0, 2'b00, 1'b1);
        stepCheck("resume", 1'b0, C_RESUME | C_STALL, 32'h0, S_HALT);
        checkState("resumed", 0, 32'h0, 1'b0, 2'b00, 1'b0);
        stepCheck("post_resume", 1'b0, C_VALID, 32'h0, S_NPC);

        // Random traffic against the reference model.
        stepCheck("rand_reset", 1'b1, 9'h000, 32'h0, S_NPC);
        m_state = 0;
        m_stack.delete();
        m_code  = 2'b00;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            c = '0;
            c[0] = ($urandom_range(0, 4) == 0);
            c[1] = ($urandom_range(0, 3) != 0);
            c[2] = ($urandom_range(0, 3) == 0);
            c[3] = ($urandom_range(0, 1) == 0);
            c[4] = ($urandom_range(0, 5) == 0);
            c[5] = ($urandom_range(0, 3) == 0);
            c[6] = ($urandom_range(0, 5) == 0);
            c[7] = ($urandom_range(0, 24) == 0);
            c[8] = ($urandom_range(0, 2) == 0);
            pc   = $urandom;
            esel = modelSel(rst, c);
            stepCheck("rand", rst, c, pc, esel);
            modelEdge(rst, c, pc);
            checkState("rand", m_stack.size(),
                       (m_stack.size() > 0) ? m_stack[$] : 32'h0,
                       (m_state == 2), m_code, (m_state == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8: return-stack entries, a power of 2, minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 32: width of return addresses.
REQ-003 SHALL have one clock and a synchronous, active-high reset (ports clock, reset); all state updates on rising clock.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  pipeline stall; freezes PC and stack.
REQ-007 instr_valid  input  1  decode-stage control inputs valid this cycle.
REQ-008 is_branch, branch_taken, is_jr, is_call, is_ret, is_halt  input  1 each  decoded control-flow class and branch outcome.
REQ-009 resume  input  1  leave HALTED state.
REQ-010 pc_1  input  ADDR_W  PC+1 (return address for call).
REQ-011 pc_select  output  3  next-address mux select: STACK=000, JR=001, NPC=010, BRANCH=011, HALT=100.
REQ-012 stack_top  output  ADDR_W  top return-stack entry (feeds mux STACK input).
REQ-013 stack_depth  output  clog2(STACK_DEPTH)+1  current occupancy.
REQ-014 halted  output  1  state is HALTED.
REQ-015 fault  output  1  state is FAULT.
REQ-016 fault_code  output  2  00 none, 01 overflow, 10 underflow; sticky until reset.

Function
REQ-017 States: RUN, HALTED, FAULT; reset enters RUN.
REQ-018 pc_select SHALL be combinational from state and current inputs (zero latency); stack/state change on the next edge.
REQ-019 In RUN with stall=1 or instr_valid=0: stall → HALT, else NPC; no stack or state change.
REQ-020 In RUN, instr_valid=1, stall=0, priority is_halt > is_ret > is_call > is_jr > (is_branch & branch_taken) > NPC; lower-priority flags ignored.
REQ-021 is_halt: pc_select=HALT; next state HALTED.
REQ-022 is_ret, depth>0: pc_select=STACK; pop at edge.
REQ-023 is_call, depth<STACK_DEPTH: pc_select=BRANCH; push pc_1 at edge.
REQ-024 is_jr: JR; branch taken: BRANCH; branch not taken: NPC.
REQ-025 is_ret with depth=0: pc_select=HALT, no pop, fault_code←10, next state FAULT.
REQ-026 is_call with depth=STACK_DEPTH: pc_select=HALT, no push, fault_code←01, next state FAULT.
REQ-027 HALTED: pc_select=HALT; resume=1 (regardless of stall) → RUN next edge; all other inputs ignored.
REQ-028 FAULT: pc_select=HALT permanently; exits only by reset; resume ignored.
REQ-029 stack_top SHALL equal the most recent pushed, unpopped entry; 0 when depth=0.
REQ-030 Full stack of STACK_DEPTH calls then STACK_DEPTH rets SHALL return addresses in exact LIFO order.
REQ-031 Stack pointer SHALL never wrap; depth bounded 0..STACK_DEPTH.

Reset
REQ-032 reset=1 SHALL win over all inputs: state RUN, depth 0, fault_code 00, stack_top 0, halted 0, fault 0.
REQ-033 Reset mid-HALTED or mid-FAULT SHALL return to RUN next edge; stack contents need not be cleared, only pointer.
REQ-034 During reset cycle pc_select SHALL be NPC.

Structure
REQ-035 pc_select encodings and fault_code values SHALL live in a shared package used by this block and the next-address mux.
REQ-036 Return stack SHALL be one sub-module, return_stack (push, pop, top, depth, full, empty); FSM and priority decode in pc_sequencer.

Verification
REQ-037 Reset, then instr_valid=1 with no flags → pc_select=010 each cycle, depth 0, fault 0.
REQ-038 call with pc_1=0x100, call with pc_1=0x200, ret, ret → pc_select 011,011,000,000; stack_top 0x100, 0x200, 0x100, 0; depth 1,2,1,0.
REQ-039 Nine calls with STACK_DEPTH=8 → ninth cycle pc_select=100, fault=1, fault_code=01, depth=8; following cycles stay 100 regardless of inputs.
REQ-040 ret at depth 0 → pc_select=100, fault_code=10, FAULT; assert reset → RUN, fault_code 00.
REQ-041 is_halt → HALTED, pc_select 100 for 5 cycles with stall toggling; resume=1 → RUN, next instr_valid no-flags cycle gives 010.
REQ-042 is_call and is_ret together at depth 1 with stall=1 → pc_select=100, depth stays 1; stall=0 → pc_select=000, depth 0.
